// File: rtl/riscv_pkg.sv
// Shared RV32 decode types: pipeline register structs, opcode constants and
// the immediate-format classification used by the decode stage.
package riscv_pkg;

  localparam int RV_XLEN = 32;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_fmt_e;

  typedef struct packed {
    logic               valid;
    logic [RV_XLEN-1:0] pc;
    logic [31:0]        instr;
  } if_id_t;

  typedef struct packed {
    logic               valid;
    logic [RV_XLEN-1:0] pc;
    logic [4:0]         rs1;
    logic [4:0]         rs2;
    logic [4:0]         rd;
    logic [RV_XLEN-1:0] rd1;
    logic [RV_XLEN-1:0] rd2;
    logic [RV_XLEN-1:0] imm;
    logic [6:0]         opcode;
    logic [2:0]         funct3;
    logic [6:0]         funct7;
  } id_ex_t;

  function automatic imm_fmt_e imm_fmt(input logic [6:0] op);
    imm_fmt_e f;
    case (op)
      OP_IMM, OP_LOAD, OP_JALR: f = IMM_I;
      OP_STORE:                 f = IMM_S;
      OP_BRANCH:                f = IMM_B;
      OP_LUI, OP_AUIPC:         f = IMM_U;
      OP_JAL:                   f = IMM_J;
      default:                  f = IMM_NONE;
    endcase
    return f;
  endfunction

  // 32-bit sign-extended immediate; callers widen to XLEN if needed.
  function automatic logic [31:0] imm_gen(input logic [31:0] i);
    logic [31:0] r;
    case (imm_fmt(i[6:0]))
      IMM_I:   r = {{20{i[31]}}, i[31:20]};
      IMM_S:   r = {{20{i[31]}}, i[31:25], i[11:7]};
      IMM_B:   r = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      IMM_U:   r = {i[31:12], 12'b0};
      IMM_J:   r = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/regfile.sv
// NREG x XLEN register file, two async read ports, one write port.
// x0 and out-of-range indices read as zero; optional write-to-read bypass.
module regfile #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int BYPASS = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      ra1,
  input  logic [4:0]      ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  input  logic            we,
  input  logic [4:0]      wa,
  input  logic [XLEN-1:0] wd
);

  localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;

  logic [XLEN-1:0] mem [NREG];
  logic            wr_ok;

  // Range check on the full 5-bit index so x20 cannot alias x4 when NREG=16.
  assign wr_ok = we & ~rst & (wa != 5'd0) & (int'(wa) < NREG);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (wr_ok) begin
      mem[wa[AW-1:0]] <= wd;
    end
  end

  always_comb begin
    rd1 = '0;
    if (ra1 != 5'd0 && int'(ra1) < NREG) begin
      if (BYPASS != 0 && wr_ok && wa == ra1) rd1 = wd;
      else                                   rd1 = mem[ra1[AW-1:0]];
    end
  end

  always_comb begin
    rd2 = '0;
    if (ra2 != 5'd0 && int'(ra2) < NREG) begin
      if (BYPASS != 0 && wr_ok && wa == ra2) rd2 = wd;
      else                                   rd2 = mem[ra2[AW-1:0]];
    end
  end

endmodule

// File: rtl/id_decode_rf.sv
// Instruction decode stage: field/immediate extraction, register read,
// load-use hazard detection and the ID/EX pipeline register.
module id_decode_rf
  import riscv_pkg::*;
#(
  parameter int XLEN   = RV_XLEN,
  parameter int NREG   = 32,
  parameter int BYPASS = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we3,
  input  logic [4:0]      a3,
  input  logic [XLEN-1:0] wd3,
  input  if_id_t          in,
  output logic            in_ready,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic            ex_is_load,
  input  logic [4:0]      ex_rd,
  output id_ex_t          out
);

  logic [4:0]      rs1, rs2, rd;
  logic [XLEN-1:0] rd1, rd2;
  logic            hazard;
  id_ex_t          dec;

  assign rs1 = in.instr[19:15];
  assign rs2 = in.instr[24:20];
  assign rd  = in.instr[11:7];

  regfile #(
    .XLEN  (XLEN),
    .NREG  (NREG),
    .BYPASS(BYPASS)
  ) u_rf (
    .clk(clk),
    .rst(rst),
    .ra1(rs1),
    .ra2(rs2),
    .rd1(rd1),
    .rd2(rd2),
    .we (we3),
    .wa (a3),
    .wd (wd3)
  );

  // rs2 is compared even for formats without one: conservative, never wrong.
  assign hazard   = in.valid & ex_is_load & (ex_rd != 5'd0) &
                    ((ex_rd == rs1) | (ex_rd == rs2));
  assign in_ready = ~rst & ~stall_i & ~hazard;

  always_comb begin
    dec = '0;
    if (in.valid) begin
      dec.valid  = 1'b1;
      dec.pc     = in.pc;
      dec.rs1    = rs1;
      dec.rs2    = rs2;
      dec.rd     = rd;
      dec.rd1    = rd1;
      dec.rd2    = rd2;
      dec.imm    = XLEN'($signed(imm_gen(in.instr)));
      dec.opcode = in.instr[6:0];
      dec.funct3 = in.instr[14:12];
      dec.funct7 = in.instr[31:25];
    end
  end

  // Bubbles are fully zeroed so downstream never sees stale fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          out <= '0;
    else if (flush_i) out <= '0;
    else if (stall_i) out <= out;
    else if (hazard)  out <= '0;
    else              out <= dec;
  end

endmodule

// File: tb/tb_id_decode_rf.sv
// Self-checking bench for id_decode_rf: decode vector table via scoreboard,
// then directed sequences for bypass, hazard, stall/flush, x0/NREG and reset.
module tb_id_decode_rf;
  import riscv_pkg::*;

  logic       clk, rst, we3, stall_i, flush_i, ex_is_load;
  logic [4:0] a3, ex_rd;
  logic [31:0] wd3;
  if_id_t     in_s;
  logic       rdy_a, rdy_nb, rdy_e;
  id_ex_t     out_a, out_nb, out_e;

  int tests = 0;
  int fails = 0;
  id_ex_t sb[$];

  id_decode_rf #(.XLEN(32), .NREG(32), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .we3(we3), .a3(a3), .wd3(wd3), .in(in_s),
    .in_ready(rdy_a), .stall_i(stall_i), .flush_i(flush_i),
    .ex_is_load(ex_is_load), .ex_rd(ex_rd), .out(out_a));

  id_decode_rf #(.XLEN(32), .NREG(32), .BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .we3(we3), .a3(a3), .wd3(wd3), .in(in_s),
    .in_ready(rdy_nb), .stall_i(stall_i), .flush_i(flush_i),
    .ex_is_load(ex_is_load), .ex_rd(ex_rd), .out(out_nb));

  id_decode_rf #(.XLEN(32), .NREG(16), .BYPASS(1)) dut_e (
    .clk(clk), .rst(rst), .we3(we3), .a3(a3), .wd3(wd3), .in(in_s),
    .in_ready(rdy_e), .stall_i(stall_i), .flush_i(flush_i),
    .ex_is_load(ex_is_load), .ex_rd(ex_rd), .out(out_e));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        v;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
  } vec_t;

  function automatic id_ex_t mk(input logic v, input logic [31:0] pc,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] rd, input logic [31:0] d1,
                                input logic [31:0] d2, input logic [31:0] imm,
                                input logic [6:0] op, input logic [2:0] f3,
                                input logic [6:0] f7);
    id_ex_t e;
    e = '0;
    if (v) begin
      e.valid = 1'b1; e.pc = pc; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd;
      e.rd1 = d1; e.rd2 = d2; e.imm = imm; e.opcode = op; e.funct3 = f3;
      e.funct7 = f7;
    end
    return e;
  endfunction

  task automatic chk_out(input string nm, input id_ex_t act, input id_ex_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  task automatic drv(input logic [31:0] instr, input logic [31:0] pc, input logic v);
    in_s.valid = v;
    in_s.pc    = pc;
    in_s.instr = instr;
  endtask

  vec_t   vecs[8];
  id_ex_t e;

  initial begin
    vecs[0] = '{32'hFFF00293, 32'h100, 1'b1, 5'd5,  5'd0, 5'd31, 32'hFFFFFFFF, 7'h13, 3'd0, 7'h7F};
    vecs[1] = '{32'h00612423, 32'h104, 1'b1, 5'd8,  5'd2, 5'd6,  32'h00000008, 7'h23, 3'd2, 7'h00};
    vecs[2] = '{32'hFE208EE3, 32'h108, 1'b1, 5'd29, 5'd1, 5'd2,  32'hFFFFFFFC, 7'h63, 3'd0, 7'h7F};
    vecs[3] = '{32'h12345537, 32'h10C, 1'b1, 5'd10, 5'd8, 5'd3,  32'h12345000, 7'h37, 3'd5, 7'h09};
    vecs[4] = '{32'h001000EF, 32'h110, 1'b1, 5'd1,  5'd0, 5'd1,  32'h00000800, 7'h6F, 3'd0, 7'h00};
    vecs[5] = '{32'h002081B3, 32'h114, 1'b1, 5'd3,  5'd1, 5'd2,  32'h00000000, 7'h33, 3'd0, 7'h00};
    vecs[6] = '{32'hFF84A203, 32'h118, 1'b1, 5'd4,  5'd9, 5'd24, 32'hFFFFFFF8, 7'h03, 3'd2, 7'h7F};
    vecs[7] = '{32'h00000013, 32'h11C, 1'b0, 5'd0,  5'd0, 5'd0,  32'h00000000, 7'h00, 3'd0, 7'h00};

    rst = 1'b1; we3 = 1'b0; a3 = '0; wd3 = '0; stall_i = 1'b0; flush_i = 1'b0;
    ex_is_load = 1'b0; ex_rd = '0;
    drv(32'hFFF00293, 32'h100, 1'b1);

    // reset state, including across a clock edge
    #1;
    chk_out("reset_out", out_a, '0);
    chk32("reset_ready", 32'(rdy_a), 32'd0);
    @(posedge clk); #1;
    chk_out("reset_hold_out", out_a, '0);
    @(negedge clk); rst = 1'b0;

    // decode table through the scoreboard
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drv(vecs[i].instr, vecs[i].pc, vecs[i].v);
      sb.push_back(mk(vecs[i].v, vecs[i].pc, vecs[i].rs1, vecs[i].rs2, vecs[i].rd,
                      32'h0, 32'h0, vecs[i].imm, vecs[i].op, vecs[i].f3, vecs[i].f7));
      @(posedge clk); #1;
      if (sb.size() == 0) chk32("sb_empty", 32'd0, 32'd1);
      else begin
        e = sb.pop_front();
        chk_out($sformatf("vec%0d", i), out_a, e);
      end
    end

    // same-cycle write/read of x7
    @(negedge clk);
    we3 = 1'b1; a3 = 5'd7; wd3 = 32'hDEADBEEF;
    drv(32'h007380B3, 32'h200, 1'b1);
    @(posedge clk); #1;
    chk_out("bypass_on", out_a, mk(1, 32'h200, 7, 7, 1, 32'hDEADBEEF, 32'hDEADBEEF, 0, 7'h33, 0, 0));
    chk32("bypass_off_rd1", out_nb.rd1, 32'h0);
    chk32("bypass_off_rd2", out_nb.rd2, 32'h0);
    @(negedge clk); we3 = 1'b0;
    @(posedge clk); #1;
    chk32("bypass_off_later", out_nb.rd1, 32'hDEADBEEF);

    // load-use hazard on rs2
    @(negedge clk);
    ex_is_load = 1'b1; ex_rd = 5'd3;
    drv(32'h003082B3, 32'h210, 1'b1);
    #1 chk32("hazard_ready", 32'(rdy_a), 32'd0);
    @(posedge clk); #1;
    chk_out("hazard_bubble", out_a, '0);
    @(negedge clk); ex_is_load = 1'b0;
    #1 chk32("hazard_clear_ready", 32'(rdy_a), 32'd1);
    @(posedge clk); #1;
    chk_out("hazard_accept", out_a, mk(1, 32'h210, 1, 3, 5, 0, 0, 0, 7'h33, 0, 0));
    @(negedge clk);
    ex_is_load = 1'b1; ex_rd = 5'd0;
    drv(32'hFFF00293, 32'h214, 1'b1);
    #1 chk32("hazard_x0_ready", 32'(rdy_a), 32'd1);
    ex_is_load = 1'b0;

    // stall+flush, then 3-cycle stall holding contents across a write
    @(posedge clk); #1;
    @(negedge clk); stall_i = 1'b1; flush_i = 1'b1;
    @(posedge clk); #1;
    chk_out("stall_flush", out_a, '0);
    @(negedge clk); stall_i = 1'b0; flush_i = 1'b0;
    drv(32'h007380B3, 32'h300, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    stall_i = 1'b1; we3 = 1'b1; a3 = 5'd7; wd3 = 32'h00000055;
    drv(32'h12345537, 32'h304, 1'b1);
    #1 chk32("stall_ready", 32'(rdy_a), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk_out($sformatf("stall_hold%0d", c), out_a,
              mk(1, 32'h300, 7, 7, 1, 32'hDEADBEEF, 32'hDEADBEEF, 0, 7'h33, 0, 0));
    end
    @(negedge clk); stall_i = 1'b0; we3 = 1'b0;
    drv(32'h007380B3, 32'h308, 1'b1);
    @(posedge clk); #1;
    chk32("after_stall_rd1", out_a.rd1, 32'h00000055);
    @(negedge clk);
    flush_i = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd3;
    drv(32'h003082B3, 32'h30C, 1'b1);
    #1 chk32("flush_hazard_ready", 32'(rdy_a), 32'd0);
    @(posedge clk); #1;
    chk_out("flush_hazard_out", out_a, '0);
    @(negedge clk); flush_i = 1'b0; ex_is_load = 1'b0;

    // x0 and out-of-range writes
    drv(32'h0, 32'h0, 1'b0);
    we3 = 1'b1; a3 = 5'd0; wd3 = 32'h00001234;
    @(negedge clk); a3 = 5'd20; wd3 = 32'h0000AAAA;
    @(negedge clk); we3 = 1'b0;
    drv(32'h000000B3, 32'h400, 1'b1);
    @(posedge clk); #1;
    chk32("x0_read", out_a.rd1, 32'h0);
    @(negedge clk); drv(32'h000A00B3, 32'h404, 1'b1);
    @(posedge clk); #1;
    chk32("x20_nreg16", out_e.rd1, 32'h0);
    chk32("x20_nreg32", out_a.rd1, 32'h0000AAAA);
    @(negedge clk); drv(32'h000200B3, 32'h408, 1'b1);
    @(posedge clk); #1;
    chk32("x4_no_alias", out_e.rd1, 32'h0);

    // asynchronous reset mid-stream
    @(negedge clk); drv(32'hFFF00293, 32'h500, 1'b1);
    @(posedge clk); #1;
    chk32("pre_reset_valid", 32'(out_a.valid), 32'd1);
    #2 rst = 1'b1; we3 = 1'b1; a3 = 5'd7; wd3 = 32'h00000999;
    #1;
    chk_out("async_reset_out", out_a, '0);
    chk32("async_reset_ready", 32'(rdy_a), 32'd0);
    @(posedge clk);
    @(negedge clk); rst = 1'b0; we3 = 1'b0;
    drv(32'h007380B3, 32'h600, 1'b1);
    @(posedge clk); #1;
    chk_out("post_reset_x7", out_a, mk(1, 32'h600, 7, 7, 1, 0, 0, 0, 7'h33, 0, 0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/id_decode_rf.md
ID_DECODE_RF -- requirements
Module: id_decode_rf

Interface
REQ-001 Parameter XLEN, 32, datapath and register width.
REQ-002 Parameter NREG, 32, architectural register count (32 RV32I, 16 RV32E); index width AW = $clog2(NREG).
REQ-003 Parameter BYPASS, 1, 1 = same-cycle write-to-read forwarding inside the register file; 0 = read returns the pre-write value.
REQ-004 clk  in  1  the single clock; all state updates on its rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 we3 / a3 / wd3  in  1 / 5 / XLEN  writeback port: enable, destination index, data.
REQ-007 in  in  if_id_t  fetched instruction: valid, pc, instr.
REQ-008 in_ready  out  1  0 when the stage cannot accept in this cycle.
REQ-009 stall_i  in  1  downstream hold: the output register keeps its contents.
REQ-010 flush_i  in  1  squash: the output register becomes a bubble.
REQ-011 ex_is_load / ex_rd  in  1 / 5  instruction currently in EX, for load-use detection.
REQ-012 out  out  id_ex_t  registered: valid, pc, rs1, rs2, rd, rd1, rd2, imm, opcode, funct3, funct7.

Function
REQ-013 Field extraction: rs1=instr[19:15], rs2=instr[24:20], rd=instr[11:7], opcode=[6:0], funct3=[14:12], funct7=[31:25].
REQ-014 Immediate, sign-extended to XLEN by opcode: I (0010011, 0000011, 1100111), S (0100011), B (1100011, bit 0 = 0), U (0110111, 0010111, low 12 bits = 0), J (1101111, bit 0 = 0); all other opcodes give 0.
REQ-015 Register file: NREG x XLEN; x0 reads 0 always; writes to x0 or to a3 >= NREG are ignored.
REQ-016 When BYPASS=1, we3 is high and a3 equals rs1 or rs2 (a3 != 0), rd1 or rd2 returns wd3 in the same cycle.
REQ-017 Source indices >= NREG read as 0.
REQ-018 hazard = in.valid & ex_is_load & (ex_rd != 0) & (ex_rd == rs1 | ex_rd == rs2); combinational.
REQ-019 in_ready = ~stall_i & ~hazard.
REQ-020 Output register update priority, highest first: flush_i -> out.valid=0; stall_i -> hold; hazard -> out.valid=0 (bubble); else capture decoded in with out.valid=in.valid.
REQ-021 Latency: exactly one cycle from in accepted to out valid.
REQ-022 When out.valid=0, all other out fields are 0.
REQ-023 A register write during stall_i updates the array, but held out.rd1/rd2 do not change.
REQ-024 flush_i together with hazard: out.valid=0, in_ready=0.

Reset
REQ-025 rst high asynchronously clears out.valid and all out fields to 0, and clears all registers to 0.
REQ-026 During rst, in_ready=0; writes on we3 are ignored.
REQ-027 Capture resumes on the first rising edge after rst deasserts; no partial decode survives a mid-stream reset.

Structure
REQ-028 Package riscv_pkg holds if_id_t, id_ex_t, the opcode constants and the immediate-format enum.
REQ-029 The register file is the sub-module regfile (parameters XLEN, NREG, BYPASS; 2 read ports, 1 write port); decode, hazard detection and the output register stay in id_decode_rf.

Verification
REQ-030 addi x5,x0,-1 (0xFFF00293), pc=0x100 -> next cycle out.valid=1, rd=5, imm=0xFFFFFFFF, pc=0x100.
REQ-031 we3=1, a3=7, wd3=0xDEADBEEF in the same cycle as add x1,x7,x7 (BYPASS=1) -> rd1=rd2=0xDEADBEEF; with BYPASS=0 -> old value 0.
REQ-032 ex_is_load=1, ex_rd=3, input rs2=3 -> in_ready=0; next cycle out.valid=0; the same instruction is accepted once ex_is_load drops.
REQ-033 stall_i=1 and flush_i=1 together -> out.valid=0; stall_i alone for 3 cycles -> out unchanged.
REQ-034 Write x0=0x1234, then read x0 -> 0; NREG=16, write x20 -> no effect, reading x20 -> 0.
REQ-035 Assert rst mid-stream with out.valid=1 -> out.valid=0 immediately, without waiting for a clock edge; x7 reads 0 afterwards.
